// File: rtl/async_pkg.sv
// Shared definitions for the clocked/async dual-rail link blocks (desync, sync).
// Rail encoding, link encoding names and the link FSM state type.
package async_pkg;

   localparam int RAIL_NUM = 2;

   localparam logic [15:0] ENC_TP = "TP";
   localparam logic [15:0] ENC_FP = "FP";

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RTZ  = 2'd2
   } state_t;

   // One dual-rail bit: rail[1] is the "one" rail, rail[0] the "zero" rail.
   typedef logic [RAIL_NUM-1:0] rail_t;

   localparam rail_t RAIL_ONE  = 2'b10;
   localparam rail_t RAIL_ZERO = 2'b01;

   function automatic rail_t encode_bit(input logic b);
      return b ? RAIL_ONE : RAIL_ZERO;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for signals arriving asynchronously to clk.
// Shared by the desync transmitter and the sync receiver.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (rst) ff <= '0;
      else     ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/desync.sv
// Clocked-to-async link transmitter: accepts words on valid/ready and drives them
// as dual-rail tokens (two-phase or four-phase RTZ), paced by the consumer's ack.
module desync
   import async_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter     ENC         = "TP",
   parameter int SYNC_STAGES = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             valid_i,
   output logic                             ready_o,
   input  logic [WIDTH-1:0]                 in,
   input  logic                             ack_i,
   output logic [WIDTH-1:0][RAIL_NUM-1:0]   out,
   output logic                             err_o
);

   // Handshake: a word transfers on a rising clk edge where valid_i && ready_o;
   // the producer holds valid_i and in stable until then, ready_o is high only in IDLE.

   localparam bit IS_FP = (ENC == ENC_FP);

   if ((ENC != ENC_TP) && (ENC != ENC_FP)) begin : g_bad_enc
      $error("desync: ENC must be \"TP\" or \"FP\"");
   end
   if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
      $error("desync: SYNC_STAGES must be in 2..4");
   end

   typedef rail_t [WIDTH-1:0] dr_word_t;

   state_t   state, state_n;
   dr_word_t out_n;
   logic     phase, phase_n;
   logic     err_n;
   logic     ack_s, ack_q;

   sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack_i),
      .q   (ack_s)
   );

   always_comb begin
      state_n = state;
      out_n   = out;
      phase_n = phase;
      err_n   = err_o;
      unique case (state)
         IDLE: begin
            // Ack must sit at its resting level while nothing is in flight.
            if (IS_FP ? ack_s : (ack_s != phase)) err_n = 1'b1;
            if (valid_i && ready_o) begin
               state_n = SEND;
               for (int i = 0; i < WIDTH; i++) begin
                  if (IS_FP) out_n[i] = encode_bit(in[i]);
                  else       out_n[i] = out[i] ^ encode_bit(in[i]);
               end
               if (!IS_FP) phase_n = ~phase;
            end
         end
         SEND: begin
            if (IS_FP) begin
               if (ack_s) begin
                  out_n   = '0;
                  state_n = RTZ;
               end else if (ack_q) begin
                  err_n = 1'b1;
               end
            end else if (ack_s == phase) begin
               state_n = IDLE;
            end
         end
         RTZ: begin
            if (!ack_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // All outputs come straight from flops; ready_o is precomputed from next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         out     <= '0;
         phase   <= 1'b0;
         ready_o <= 1'b1;
         err_o   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state   <= state_n;
         out     <= out_n;
         phase   <= phase_n;
         ready_o <= (state_n == IDLE);
         err_o   <= err_n;
         ack_q   <= ack_s;
      end
   end

endmodule

// File: tb/tb_desync.sv
// Bench for desync: one TP and one FP instance, a token-counting reference model
// compared every cycle, plus directed scenarios with hand-computed rail values.
module tb_desync;

   localparam int W    = 8;
   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic            valid_tp = 1'b0, ack_tp = 1'b0, ready_tp, err_tp;
   logic [W-1:0]    in_tp = '0;
   logic [W-1:0][1:0] out_tp;
   logic            valid_fp = 1'b0, ack_fp = 1'b0, ready_fp, err_fp;
   logic [W-1:0]    in_fp = '0;
   logic [W-1:0][1:0] out_fp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   desync #(.WIDTH(W), .ENC("TP"), .SYNC_STAGES(SYNC)) dut_tp (
      .clk(clk), .rst(rst), .valid_i(valid_tp), .ready_o(ready_tp), .in(in_tp),
      .ack_i(ack_tp), .out(out_tp), .err_o(err_tp)
   );

   desync #(.WIDTH(W), .ENC("FP"), .SYNC_STAGES(SYNC)) dut_fp (
      .clk(clk), .rst(rst), .valid_i(valid_fp), .ready_o(ready_fp), .in(in_fp),
      .ack_i(ack_fp), .out(out_fp), .err_o(err_fp)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: TP rails are the parity of how many tokens put a 1 (or 0) on each bit.
   bit           model_ok = 1'b0;
   int unsigned  m_cnt1[W], m_cnt0[W];
   bit           m_tp_busy, m_tp_phase, m_tp_err;
   bit [SYNC-1:0] m_tp_pipe;
   int           m_fp_mode;
   bit           m_fp_show, m_fp_err, m_fp_prev;
   bit [W-1:0]   m_fp_word;
   bit [SYNC-1:0] m_fp_pipe;

   function automatic logic [15:0] tp_exp();
      logic [15:0] r;
      for (int i = 0; i < W; i++) begin
         r[2*i+1] = (m_cnt1[i] % 2) == 1;
         r[2*i]   = (m_cnt0[i] % 2) == 1;
      end
      return r;
   endfunction

   function automatic logic [15:0] fp_exp();
      logic [15:0] r;
      r = '0;
      if (m_fp_show)
         for (int i = 0; i < W; i++) begin
            r[2*i+1] = m_fp_word[i];
            r[2*i]   = ~m_fp_word[i];
         end
      return r;
   endfunction

   always @(posedge clk) begin
      bit acks;
      if (rst) begin
         for (int i = 0; i < W; i++) begin
            m_cnt1[i] = 0;
            m_cnt0[i] = 0;
         end
         m_tp_busy = 0; m_tp_phase = 0; m_tp_err = 0; m_tp_pipe = '0;
         m_fp_mode = 0; m_fp_show = 0; m_fp_err = 0; m_fp_prev = 0; m_fp_pipe = '0;
         m_fp_word = '0;
         model_ok  = 1'b1;
      end else begin
         acks = m_tp_pipe[SYNC-1];
         if (!m_tp_busy) begin
            if (acks != m_tp_phase) m_tp_err = 1;
            if (valid_tp) begin
               m_tp_busy  = 1;
               m_tp_phase = ~m_tp_phase;
               for (int i = 0; i < W; i++)
                  if (in_tp[i]) m_cnt1[i]++;
                  else          m_cnt0[i]++;
            end
         end else if (acks == m_tp_phase) begin
            m_tp_busy = 0;
         end
         m_tp_pipe = {m_tp_pipe[SYNC-2:0], ack_tp};

         acks = m_fp_pipe[SYNC-1];
         case (m_fp_mode)
            0: begin
               if (acks) m_fp_err = 1;
               if (valid_fp) begin
                  m_fp_mode = 1; m_fp_word = in_fp; m_fp_show = 1;
               end
            end
            1: begin
               if (acks) begin
                  m_fp_show = 0; m_fp_mode = 2;
               end else if (m_fp_prev) begin
                  m_fp_err = 1;
               end
            end
            default: if (!acks) m_fp_mode = 0;
         endcase
         m_fp_prev = acks;
         m_fp_pipe = {m_fp_pipe[SYNC-2:0], ack_fp};
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("tp_out",   out_tp,   tp_exp());
         check("tp_ready", {15'd0, ready_tp}, {15'd0, !m_tp_busy});
         check("tp_err",   {15'd0, err_tp},   {15'd0, m_tp_err});
         check("fp_out",   out_fp,   fp_exp());
         check("fp_ready", {15'd0, ready_fp}, {15'd0, m_fp_mode == 0});
         check("fp_err",   {15'd0, err_fp},   {15'd0, m_fp_err});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tp_ready(input string name);
      int n = 0;
      while (!ready_tp && n < 40) begin tick(); n++; end
      check(name, {15'd0, ready_tp}, 16'd1);
   endtask

   task automatic wait_fp_ready(input string name);
      int n = 0;
      while (!ready_fp && n < 40) begin tick(); n++; end
      check(name, {15'd0, ready_fp}, 16'd1);
   endtask

   task automatic send_tp(input logic [W-1:0] d);
      wait_tp_ready("tp_pre_send_ready");
      in_tp = d; valid_tp = 1'b1;
      tick();
      valid_tp = 1'b0;
   endtask

   logic [W-1:0] hold_vals [4] = '{8'h77, 8'hC3, 8'h0F, 8'hE8};

   initial begin
      int n;
      tick(); tick(); tick();
      rst = 1'b0;
      check("rst_tp_out",   out_tp, 16'h0000);
      check("rst_tp_ready", {15'd0, ready_tp}, 16'd1);
      check("rst_tp_err",   {15'd0, err_tp}, 16'd0);
      check("rst_fp_out",   out_fp, 16'h0000);

      // TP token 0xA5, then the ack round trip latency
      send_tp(8'hA5);
      check("tp_a5_rails", out_tp, 16'h9966);
      check("tp_a5_busy",  {15'd0, ready_tp}, 16'd0);
      ack_tp = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!ready_tp && n < 20);
      check("tp_ack_latency", 16'(n), 16'(SYNC + 1));

      // Same word again: every rail toggles back
      send_tp(8'hA5);
      check("tp_a5_again_rails", out_tp, 16'h0000);
      ack_tp = 1'b0;
      wait_tp_ready("tp_a5_again_ready");
      check("tp_a5_again_err", {15'd0, err_tp}, 16'd0);

      // Backpressure: valid held, in changing during SEND
      in_tp = 8'h12; valid_tp = 1'b1;
      tick();
      check("tp_bp_first", out_tp, 16'h5659);
      for (int k = 0; k < 4; k++) begin
         in_tp = hold_vals[k];
         tick();
         check("tp_bp_hold", out_tp, 16'h5659);
      end
      in_tp = 8'h34; ack_tp = 1'b1;
      n = 0;
      while (!ready_tp && n < 40) begin tick(); n++; end
      check("tp_bp_ready", {15'd0, ready_tp}, 16'd1);
      tick();
      valid_tp = 1'b0;
      check("tp_bp_second", out_tp, 16'h0C3C);
      check("tp_bp_second_busy", {15'd0, ready_tp}, 16'd0);
      ack_tp = 1'b0;
      wait_tp_ready("tp_bp_done");

      // Spurious ack while idle
      ack_tp = 1'b1;
      repeat (SYNC + 2) tick();
      check("tp_spurious_err", {15'd0, err_tp}, 16'd1);
      check("tp_spurious_out", out_tp, 16'h0C3C);
      repeat (3) tick();
      check("tp_err_sticky", {15'd0, err_tp}, 16'd1);
      rst = 1'b1; ack_tp = 1'b0;
      tick();
      rst = 1'b0;
      check("tp_err_cleared", {15'd0, err_tp}, 16'd0);
      check("tp_rst_out", out_tp, 16'h0000);

      // Reset in the middle of SEND with phase = 1
      send_tp(8'h55);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("tp_midrst_out",   out_tp, 16'h0000);
      check("tp_midrst_ready", {15'd0, ready_tp}, 16'd1);
      send_tp(8'hFF);
      check("tp_ff_rails", out_tp, 16'hAAAA);
      ack_tp = 1'b1;
      wait_tp_ready("tp_ff_ready");
      check("tp_ff_err", {15'd0, err_tp}, 16'd0);

      // FP token 0x3C through SEND and RTZ
      wait_fp_ready("fp_pre_ready");
      in_fp = 8'h3C; valid_fp = 1'b1;
      tick();
      valid_fp = 1'b0;
      check("fp_3c_rails", out_fp, 16'h5AA5);
      check("fp_3c_busy",  {15'd0, ready_fp}, 16'd0);
      ack_fp = 1'b1;
      n = 0;
      while (out_fp !== '0 && n < 40) begin tick(); n++; end
      check("fp_rtz_out",   out_fp, 16'h0000);
      check("fp_rtz_ready", {15'd0, ready_fp}, 16'd0);
      ack_fp = 1'b0;
      wait_fp_ready("fp_done_ready");
      check("fp_err", {15'd0, err_fp}, 16'd0);

      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
